branch_history_table: RTL and testbench

//  Direction predictor that feeds fetch/issue and consumes the single-cycle bp_update pulse

---
 rtl/branch_history_table_pkg.sv | 21 ++
 rtl/branch_history_table_sat_counter2.sv | 19 +
 rtl/branch_history_table.sv | 158 +++++++++++++++
 tb/tb_branch_history_table.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_history_table_pkg.sv
// Shared CPU types for the branch predictor: resolved-branch update bundle,
// predictor sweep states and the counter value written by the init sweep.
package branch_history_table_pkg;

   // Single-cycle branch resolution report from the execution-condition register file
   typedef struct packed {
      logic        en;
      logic [31:0] pc;
      logic        actual_taken;
   } bp_update_t;

   // Predictor table state: sweeping the array, or answering lookups
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bht_state_e;

   // Weakly not-taken: one taken resolution flips the prediction
   localparam logic [1:0] BHT_WEAK_NT = 2'b01;

endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// bp_sat_counter2: next-state of a 2-bit saturating direction counter.
// Kept as its own module so a later tournament chooser can reuse it.
module bp_sat_counter2 (
   input  logic [1:0] old_cnt,
   input  logic       taken,
   output logic [1:0] new_cnt
);

   // Count toward the resolved direction, clamping at 2'b00 and 2'b11
   always_comb begin
      new_cnt = old_cnt;
      if (taken) begin
         if (old_cnt != 2'b11) new_cnt = old_cnt + 2'd1;
      end else begin
         if (old_cnt != 2'b00) new_cnt = old_cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_history_table.sv
// branch_history_table: 2-bit saturating-counter direction predictor with a
// sequential initialisation sweep after reset/flush and two saturating
// performance counters.
// Build option: define BP_GSHARE_EN to XOR a global history register into
// both the lookup and the update index (gshare); undefined gives a plain
// PC-indexed bimodal table with identical ports.
module branch_history_table
   import branch_history_table_pkg::*;
#(
   parameter int BHT_ENTRIES = 64,
   parameter int HIST_W      = 6,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  bp_update_t       bp_update,
   input  logic [31:0]      lookup_pc,
   output logic             pred_taken,
   output logic             pred_ready,
   input  logic             flush_req,
   output logic [CNT_W-1:0] perf_updates,
   output logic [CNT_W-1:0] perf_mispred
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   bht_state_e       state_reg;
   logic [IDX_W-1:0] init_idx_reg;
   logic [CNT_W-1:0] perf_updates_reg;
   logic [CNT_W-1:0] perf_mispred_reg;

   logic [1:0]       cnt_arr [BHT_ENTRIES];
   logic [IDX_W-1:0] ghr_ext;
   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [1:0]       upd_old;
   logic [1:0]       upd_new;
   logic             upd_accept;
   logic             init_last;
   logic             unused_bits;

`ifdef BP_GSHARE_EN
   logic [HIST_W-1:0] ghr_reg;

   // Zero-extend the history to index width
   always_comb begin
      ghr_ext               = '0;
      ghr_ext[HIST_W-1:0]   = ghr_reg;
   end

   // Global history: shift in each accepted outcome, clear on flush / re-init
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr_reg <= '0;
      end else if (state_reg == INIT || flush_req) begin
         ghr_reg <= '0;
      end else if (upd_accept) begin
         ghr_reg <= HIST_W'({ghr_reg, bp_update.actual_taken});
      end
   end

   assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                          bp_update.pc[31:IDX_W+2], bp_update.pc[1:0]};
`else
   assign ghr_ext     = '0;
   assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                          bp_update.pc[31:IDX_W+2], bp_update.pc[1:0], 1'(HIST_W)};
`endif

   // Table indices; the update side uses the history as it stands at resolve time
   always_comb begin
      lookup_idx = lookup_pc[IDX_W+1:2] ^ ghr_ext;
      upd_idx    = bp_update.pc[IDX_W+1:2] ^ ghr_ext;
   end

   assign upd_accept = bp_update.en && (state_reg == RUN) && !flush_req;
   assign init_last  = (init_idx_reg == IDX_W'(BHT_ENTRIES - 1));
   assign upd_old    = cnt_arr[upd_idx];

   bp_sat_counter2 u_sat (
      .old_cnt (upd_old),
      .taken   (bp_update.actual_taken),
      .new_cnt (upd_new)
   );

   // Sweep / run state machine; flush restarts the sweep from entry 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= INIT;
         init_idx_reg <= '0;
      end else begin
         case (state_reg)
            INIT: begin
               if (flush_req) begin
                  init_idx_reg <= '0;
               end else if (init_last) begin
                  state_reg    <= RUN;
                  init_idx_reg <= '0;
               end else begin
                  init_idx_reg <= init_idx_reg + 1'b1;
               end
            end
            RUN: begin
               if (flush_req) begin
                  state_reg    <= INIT;
                  init_idx_reg <= '0;
               end
            end
            default: begin
               state_reg    <= INIT;
               init_idx_reg <= '0;
            end
         endcase
      end
   end

   // Counter array: contents are don't-care until the sweep rewrites them,
   // so the entries carry no reset
   genvar gi;
   generate
      for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_cnt
         logic [1:0] cnt_reg;

         // Sweep write has priority; otherwise take the accepted update
         always_ff @(posedge clk) begin
            if (state_reg == INIT && init_idx_reg == IDX_W'(gi)) begin
               cnt_reg <= BHT_WEAK_NT;
            end else if (upd_accept && upd_idx == IDX_W'(gi)) begin
               cnt_reg <= upd_new;
            end
         end

         assign cnt_arr[gi] = cnt_reg;
      end
   endgenerate

   // Performance counters saturate at all-ones; only rst_n clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_updates_reg <= '0;
         perf_mispred_reg <= '0;
      end else if (upd_accept) begin
         if (~&perf_updates_reg) perf_updates_reg <= perf_updates_reg + 1'b1;
         if (upd_old[1] != bp_update.actual_taken && ~&perf_mispred_reg)
            perf_mispred_reg <= perf_mispred_reg + 1'b1;
      end
   end

   // Zero-latency lookup, no bypass from a same-cycle update; forced low while sweeping
   always_comb begin
      pred_ready = (state_reg == RUN);
      pred_taken = pred_ready & cnt_arr[lookup_idx][1];
   end

   assign perf_updates = perf_updates_reg;
   assign perf_mispred = perf_mispred_reg;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table (64 entries, 32-bit perf counters).
// Default build exercises the bimodal table; with BP_GSHARE_EN it exercises
// the history-XOR indexing instead.
module tb_branch_history_table;
   import branch_history_table_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_req = 1'b0;
   bp_update_t  bp_update = '0;
   logic [31:0] lookup_pc = '0;
   logic        pred_taken;
   logic        pred_ready;
   logic [31:0] perf_updates;
   logic [31:0] perf_mispred;

   int pass_cnt  = 0;
   int total_cnt = 0;

   branch_history_table #(
      .BHT_ENTRIES (64),
      .HIST_W      (6),
      .CNT_W       (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bp_update    (bp_update),
      .lookup_pc    (lookup_pc),
      .pred_taken   (pred_taken),
      .pred_ready   (pred_ready),
      .flush_req    (flush_req),
      .perf_updates (perf_updates),
      .perf_mispred (perf_mispred)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle update pulse; returns the prediction seen for pc in the update cycle
   task automatic do_update(input logic [31:0] pc, input logic taken, output logic pre_pred);
      bp_update.en           = 1'b1;
      bp_update.pc           = pc;
      bp_update.actual_taken = taken;
      lookup_pc              = pc;
      #1;
      pre_pred = pred_taken;
      tick();
      bp_update.en = 1'b0;
      #1;
      $display("update pc=%08h taken=%0d pre_pred=%0d post_pred=%0d perf=%0d/%0d",
               pc, taken, pre_pred, pred_taken, perf_updates, perf_mispred);
   endtask

   // Expects INIT just entered: 64 cycles not ready, then ready
   task automatic wait_sweep(input string tag, input bit poke_update);
      for (int k = 0; k < 64; k++) begin
         lookup_pc = 32'(k) << 2;
         if (poke_update && k == 10) begin
            bp_update.en = 1'b1; bp_update.pc = 32'h100; bp_update.actual_taken = 1'b1;
         end
         #1;
         total_cnt++;
         if (pred_ready !== 1'b0 || pred_taken !== 1'b0)
            $display("FAIL %s_init_low cycle=%0d ready=%0b taken=%0b required 0/0",
                     tag, k, pred_ready, pred_taken);
         else pass_cnt++;
         tick();
         bp_update.en = 1'b0;
      end
      total_cnt++;
      if (pred_ready !== 1'b1)
         $display("FAIL %s_ready_after_64 ready=%0b required 1", tag, pred_ready);
      else pass_cnt++;
      $display("sweep %s done ready=%0b", tag, pred_ready);
   endtask

   task automatic check_all_not_taken(input string tag);
      for (int i = 0; i < 64; i++) begin
         lookup_pc = 32'(i) << 2;
         #1;
         total_cnt++;
         if (pred_taken !== 1'b0)
            $display("FAIL %s_entry%0d pred=%0b required 0", tag, i, pred_taken);
         else pass_cnt++;
      end
   endtask

   task automatic check_perf(input string tag, input int exp_upd, input int exp_mis);
      total_cnt++;
      if (perf_updates !== 32'(exp_upd))
         $display("FAIL %s_perf_updates got=%0d required %0d", tag, perf_updates, exp_upd);
      else pass_cnt++;
      total_cnt++;
      if (perf_mispred !== 32'(exp_mis))
         $display("FAIL %s_perf_mispred got=%0d required %0d", tag, perf_mispred, exp_mis);
      else pass_cnt++;
   endtask

   task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
      lookup_pc = pc;
      #1;
      total_cnt++;
      if (pred_taken !== exp)
         $display("FAIL %s pc=%08h pred=%0b required %0b", tag, pc, pred_taken, exp);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      total_cnt++;
      if (pred_ready !== 1'b0 || pred_taken !== 1'b0)
         $display("FAIL reset_outputs ready=%0b taken=%0b required 0/0", pred_ready, pred_taken);
      else pass_cnt++;
      check_perf("reset", 0, 0);
      rst_n = 1'b1;
      wait_sweep("reset", 1'b0);
      check_all_not_taken("reset");
      check_perf("reset_run", 0, 0);
   endtask

   task automatic test_bimodal();
      logic pre;
      logic exp_pre [3] = '{1'b0, 1'b1, 1'b1};
      for (int n = 0; n < 3; n++) begin
         do_update(32'h100, 1'b1, pre);
         total_cnt++;
         if (pre !== exp_pre[n])
            $display("FAIL bimodal_pred_%0d got=%0b required %0b", n, pre, exp_pre[n]);
         else pass_cnt++;
      end
      check_pred("bimodal_final", 32'h100, 1'b1);
      check_perf("bimodal", 3, 1);
   endtask

   // Back-to-back taken pulses saturate at 11, then two not-taken walk down to 01
   task automatic test_back_to_back_saturation();
      logic pre;
      bp_update.en = 1'b1; bp_update.pc = 32'h104; bp_update.actual_taken = 1'b1;
      lookup_pc = 32'h104;
      repeat (5) tick();
      bp_update.en = 1'b0;
      $display("burst 5 taken pc=00000104 perf=%0d/%0d", perf_updates, perf_mispred);
      check_perf("burst", 8, 2);
      check_pred("alias_0x204", 32'h204, 1'b1);
      check_pred("neighbour_0x108", 32'h108, 1'b0);
      do_update(32'h104, 1'b0, pre);
      check_pred("sat_after_1nt", 32'h104, 1'b1);
      do_update(32'h104, 1'b0, pre);
      check_pred("sat_after_2nt", 32'h104, 1'b0);
      check_perf("saturation", 10, 4);
   endtask

   task automatic test_same_cycle();
      logic pre;
      do_update(32'h100, 1'b0, pre);
      do_update(32'h100, 1'b0, pre);
      check_pred("same_cycle_setup", 32'h100, 1'b0);
      do_update(32'h100, 1'b1, pre);
      total_cnt++;
      if (pre !== 1'b0)
         $display("FAIL same_cycle_no_bypass got=%0b required 0", pre);
      else pass_cnt++;
      check_pred("same_cycle_next", 32'h100, 1'b1);
      check_perf("same_cycle", 13, 7);
   endtask

   task automatic test_flush_update();
      flush_req = 1'b1;
      bp_update.en = 1'b1; bp_update.pc = 32'h100; bp_update.actual_taken = 1'b0;
      tick();
      flush_req = 1'b0;
      bp_update.en = 1'b0;
      $display("flush with coincident update perf=%0d/%0d", perf_updates, perf_mispred);
      check_perf("flush_drop", 13, 7);
      wait_sweep("flush", 1'b1);
      check_perf("init_drop", 13, 7);
      check_all_not_taken("flush");
   endtask

`ifdef BP_GSHARE_EN
   task automatic test_gshare();
      logic pre;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      wait_sweep("gs_flush1", 1'b0);
      do_update(32'h0, 1'b1, pre);
      do_update(32'h0, 1'b1, pre);
      check_pred("gs_0x0_entry3", 32'h0, 1'b0);
      check_pred("gs_0xC_entry0", 32'h0C, 1'b1);
      check_pred("gs_0x8_entry1", 32'h08, 1'b1);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      wait_sweep("gs_flush2", 1'b0);
      do_update(32'h0, 1'b1, pre);
      check_pred("gs_cleared_0x4", 32'h04, 1'b1);
      check_pred("gs_cleared_0x0", 32'h0, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
`ifdef BP_GSHARE_EN
      test_gshare();
`else
      test_bimodal();
      test_back_to_back_saturation();
      test_same_cycle();
      test_flush_update();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
